// File: rtl/tmds_encoder_8b10b.sv
// rtl/tmds_encoder_8b10b.sv - DVI TMDS 8b/10b channel encoder, two-stage pipeline
module tmds_encoder_8b10b #(
  parameter int CNT_WIDTH = 5
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_de,
  input  logic       I_c0,
  input  logic       I_c1,
  input  logic [7:0] I_data,
  output logic [9:0] O_tmds
);

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;
  localparam int         PAD      = CNT_WIDTH - 4;

  localparam logic signed [CNT_WIDTH-1:0] TWO  = CNT_WIDTH'(2);
  localparam logic signed [CNT_WIDTH-1:0] ZERO = '0;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Transition-minimised word; bit 8 flags XOR (1) or XNOR (0) chaining.
  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  logic       de_q;
  logic [1:0] c_q;
  logic [8:0] qm_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q <= 1'b0;
      c_q  <= 2'b00;
      qm_q <= 9'd0;
    end else begin
      de_q <= I_de;
      c_q  <= {I_c1, I_c0};
      qm_q <= min_trans(I_data);
    end
  end

  logic signed [CNT_WIDTH-1:0] cnt_q;
  logic signed [CNT_WIDTH-1:0] cnt_d;
  logic signed [CNT_WIDTH-1:0] n1_s;
  logic signed [CNT_WIDTH-1:0] n0_s;
  logic signed [CNT_WIDTH-1:0] diff;
  logic [3:0]                  n1q;
  logic [3:0]                  n0q;
  logic [9:0]                  tmds_d;
  logic                        cnt_pos;
  logic                        cnt_neg;

  always_comb begin
    n1q     = ones8(qm_q[7:0]);
    n0q     = 4'd8 - n1q;
    n1_s    = $signed({{PAD{1'b0}}, n1q});
    n0_s    = $signed({{PAD{1'b0}}, n0q});
    diff    = n1_s - n0_s;
    cnt_neg = cnt_q[CNT_WIDTH-1];
    cnt_pos = !cnt_neg && (cnt_q != ZERO);
    tmds_d  = TOKEN_00;
    cnt_d   = cnt_q;
    if (!de_q) begin
      // Blanking resets disparity so each active line starts balanced.
      cnt_d = ZERO;
      case (c_q)
        2'b00:   tmds_d = TOKEN_00;
        2'b01:   tmds_d = TOKEN_01;
        2'b10:   tmds_d = TOKEN_10;
        default: tmds_d = TOKEN_11;
      endcase
    end else if ((cnt_q == ZERO) || (n1q == n0q)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q))) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + (qm_q[8] ? TWO : ZERO) - diff;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q - (qm_q[8] ? ZERO : TWO) + diff;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q  <= ZERO;
      O_tmds <= TOKEN_00;
    end else begin
      cnt_q  <= cnt_d;
      O_tmds <= tmds_d;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// tb/tb_tmds_encoder_8b10b.sv - directed and model-checked bench for tmds_encoder_8b10b
module tb_tmds_encoder_8b10b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic [7:0] data = 8'h00;
  logic [9:0] tmds;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt = 0;

  logic [9:0] p_exp [2];
  bit         p_chk [2];
  string      p_tag [2];

  tmds_encoder_8b10b #(.CNT_WIDTH(5)) dut (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .I_de   (de),
    .I_c0   (c0),
    .I_c1   (c1),
    .I_data (data),
    .O_tmds (tmds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pipe_clear();
    for (int i = 0; i < 2; i++) begin
      p_chk[i] = 1'b0;
      p_exp[i] = 10'h0;
      p_tag[i] = "";
    end
  endtask

  // Output seen at a negedge belongs to the input driven two negedges earlier.
  task automatic step(input logic s_de, input logic s_c1, input logic s_c0,
                      input logic [7:0] s_d, input logic [9:0] exp,
                      input bit chk, input string tag);
    @(negedge clk);
    if (p_chk[1]) check(p_tag[1], tmds, p_exp[1]);
    p_exp[1] = p_exp[0];
    p_chk[1] = p_chk[0];
    p_tag[1] = p_tag[0];
    p_exp[0] = exp;
    p_chk[0] = chk;
    p_tag[0] = tag;
    de   = s_de;
    c1   = s_c1;
    c0   = s_c0;
    data = s_d;
  endtask

  function automatic logic [9:0] ref_enc(input logic r_de, input logic r_c1,
                                         input logic r_c0, input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] o;
    int         n1;
    int         a;
    int         b;
    bit         xn;
    if (!r_de) begin
      m_cnt = 0;
      case ({r_c1, r_c0})
        2'b00:   return 10'b1101010100;
        2'b01:   return 10'b0010101011;
        2'b10:   return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1    = $countones(d);
    xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    a = $countones(qm[7:0]);
    b = 8 - a;
    if (m_cnt == 0 || a == b) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_cnt += qm[8] ? (a - b) : (b - a);
    end else if ((m_cnt > 0 && a > b) || (m_cnt < 0 && b > a)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      m_cnt += 2 * int'(qm[8]) + b - a;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      m_cnt += -2 * int'(!qm[8]) + a - b;
    end
    return o;
  endfunction

  task automatic rstep(input logic s_de, input logic s_c1, input logic s_c0,
                       input logic [7:0] s_d);
    logic [9:0] e;
    e = ref_enc(s_de, s_c1, s_c0, s_d);
    step(s_de, s_c1, s_c0, s_d, e, 1'b1, "soak");
  endtask

  initial begin
    pipe_clear();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      de   = 1'($urandom);
      c0   = 1'($urandom);
      c1   = 1'($urandom);
      data = 8'($urandom);
      check("reset_hold", tmds, 10'h354);
    end
    @(negedge clk);
    de = 1'b0; c0 = 1'b0; c1 = 1'b0; data = 8'h00;
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00, 10'h354, 1'b1, "post_reset_a");
    step(0, 0, 0, 8'h00, 10'h354, 1'b1, "post_reset_b");

    // Control tokens; data is don't-care while blanking
    step(0, 0, 0, 8'hA5, 10'h354, 1'b1, "tok_00");
    step(0, 0, 1, 8'h3C, 10'h0AB, 1'b1, "tok_01");
    step(0, 1, 0, 8'hFF, 10'h154, 1'b1, "tok_10");
    step(0, 1, 1, 8'h81, 10'h2AB, 1'b1, "tok_11");

    // Sustained zeros: disparity -8, 2, -6, 4
    step(1, 0, 0, 8'h00, 10'h100, 1'b1, "dc_zero_1");
    step(1, 0, 0, 8'h00, 10'h3FF, 1'b1, "dc_zero_2");
    step(1, 0, 0, 8'h00, 10'h100, 1'b1, "dc_zero_3");
    step(1, 0, 0, 8'h00, 10'h3FF, 1'b1, "dc_zero_4");
    step(0, 0, 0, 8'h00, 10'h354, 1'b1, "blank_a");
    step(1, 0, 0, 8'hFF, 10'h200, 1'b1, "dc_ones");
    step(0, 1, 0, 8'h00, 10'h154, 1'b1, "blank_b");

    // Balanced word with control bits set: must be ignored during active video
    step(1, 1, 1, 8'h55, 10'h133, 1'b1, "bal_1");
    step(1, 1, 1, 8'h55, 10'h133, 1'b1, "bal_2");
    step(1, 0, 1, 8'h55, 10'h133, 1'b1, "bal_3");

    // Single blanking symbol clears disparity
    step(0, 0, 0, 8'h00, 10'h354, 1'b1, "blank_c");
    step(1, 0, 0, 8'h00, 10'h100, 1'b1, "drop_first");
    step(0, 0, 0, 8'h00, 10'h354, 1'b1, "drop_blank");
    step(1, 0, 0, 8'h00, 10'h100, 1'b1, "drop_second");

    // Random soak from a known-balanced start
    m_cnt = 0;
    rstep(0, 0, 0, 8'h00);
    for (int i = 0; i < 1500; i++)
      rstep(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 8'($urandom));

    // Mid-stream asynchronous reset during active data
    for (int i = 0; i < 6; i++) rstep(1, 0, 0, 8'($urandom));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", tmds, 10'h354);
    @(negedge clk);
    check("reset_low", tmds, 10'h354);
    de = 1'b0; c0 = 1'b0; c1 = 1'b0; data = 8'h00;
    rst_n = 1'b1;
    pipe_clear();
    m_cnt = 0;
    rstep(1, 0, 0, 8'h00);
    rstep(1, 0, 0, 8'h00);
    for (int i = 0; i < 1500; i++)
      rstep(($urandom_range(0, 1) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
    step(0, 0, 0, 8'h00, 10'h354, 1'b0, "flush_a");
    step(0, 0, 0, 8'h00, 10'h354, 1'b0, "flush_b");
    step(0, 0, 0, 8'h00, 10'h354, 1'b0, "flush_c");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
